// File: rtl/mainfsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving datapath enables, mux selects and aluop.
//
// state   | meaning
// --------+------------------------------------------------
// FETCH   | read instruction, PC <= PC + 4
// DECODE  | read registers, precompute branch target
// MEMADR  | compute load/store address
// MEMRD   | read data memory
// MEMWB   | write loaded data to register file
// MEMWR   | write data memory
// EXECUTE | R-type ALU operation
// ALUWB   | write ALU result to rd
// BRANCH  | compare for beq, select branch target
// ADDIEX  | add immediate
// ADDIWB  | write addi result to rt
// JUMP    | load jump target into PC
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic       branch,
  output logic       pcwrite,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = S_FETCH;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    pcwrite  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for mainfsm: walks each instruction class through its state
// sequence and checks every output against a table of expected Moore outputs.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       memwrite, irwrite, regwrite, iord, memtoreg, regdst;
  logic       alusrca, branch, pcwrite;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .branch(branch), .pcwrite(pcwrite),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,branch,pcwrite,alusrcb,pcsrc,aluop}
  function automatic logic [14:0] exp_out(input logic [3:0] s);
    case (s)
      4'd0:    return {9'b010000001, 2'b01, 2'b00, 2'b00};
      4'd1:    return {9'b000000000, 2'b11, 2'b00, 2'b00};
      4'd2:    return {9'b000000100, 2'b10, 2'b00, 2'b00};
      4'd3:    return {9'b000100000, 2'b00, 2'b00, 2'b00};
      4'd4:    return {9'b001010000, 2'b00, 2'b00, 2'b00};
      4'd5:    return {9'b100100000, 2'b00, 2'b00, 2'b00};
      4'd6:    return {9'b000000100, 2'b00, 2'b00, 2'b10};
      4'd7:    return {9'b001001000, 2'b00, 2'b00, 2'b00};
      4'd8:    return {9'b000000110, 2'b00, 2'b01, 2'b01};
      4'd9:    return {9'b000000100, 2'b10, 2'b00, 2'b00};
      4'd10:   return {9'b001000000, 2'b00, 2'b00, 2'b00};
      4'd11:   return {9'b000000001, 2'b00, 2'b10, 2'b00};
      default: return 15'd0;
    endcase
  endfunction

  function automatic logic [14:0] obs_out();
    return {memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
            branch, pcwrite, alusrcb, pcsrc, aluop};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives op from a FETCH cycle and checks n+1 samples (ending at FETCH).
  task automatic run(input string name, input logic [5:0] o, input int n,
                     input logic [0:5][3:0] seq, input int exp_mw, input int exp_rw);
    int mw = 0;
    int rw = 0;
    int iw = 0;
    op = o;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) @(negedge clk);
      chk({name, " state"}, {28'd0, state}, {28'd0, seq[i]});
      chk({name, " outputs"}, {17'd0, obs_out()}, {17'd0, exp_out(seq[i])});
      chk({name, " aluop!=11"}, {31'd0, aluop == 2'b11}, 32'd0);
      if (i < n) begin
        mw += int'(memwrite);
        rw += int'(regwrite);
        iw += int'(irwrite);
      end
    end
    chk({name, " memwrite cycles"}, mw, exp_mw);
    chk({name, " regwrite cycles"}, rw, exp_rw);
    chk({name, " irwrite cycles"}, iw, 1);
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    #2;
    chk("reset state", {28'd0, state}, 32'd0);
    chk("reset outputs", {17'd0, obs_out()}, {17'd0, exp_out(4'd0)});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("idle fetch", {28'd0, state}, 32'd0);

    run("lw",   6'b100011, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 0, 1);

    // Asynchronous reset in MEMRD, asserted between edges.
    op = 6'b100011;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset memrd", {28'd0, state}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("async reset state", {28'd0, state}, 32'd0);
    chk("async reset outputs", {17'd0, obs_out()}, {17'd0, exp_out(4'd0)});
    @(negedge clk);
    chk("held in reset", {28'd0, state}, 32'd0);
    chk("no strobe in reset", {30'd0, memwrite, regwrite}, 32'd0);
    reset = 1'b0;
    op = 6'b111111;
    @(negedge clk);
    chk("first edge after reset", {28'd0, state}, 32'd1);
    @(negedge clk);
    chk("back to fetch", {28'd0, state}, 32'd0);

    run("sw",    6'b101011, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}, 1, 0);
    run("rtype", 6'b000000, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 0, 1);
    run("beq",   6'b000100, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}, 0, 0);
    run("j",     6'b000010, 3, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0, 4'd0}, 0, 0);
    run("addi",  6'b001000, 4, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 0, 1);
    run("unsup", 6'b111111, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 0, 0);
    run("lw2",   6'b100011, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
